univ_shift_reg_burst: RTL and testbench

Parametrised successor to the team's 4-bit universal shift register.
- Register width is generic.
- Adds serial inputs and a registered serial output.
- Adds rotate, logical shift and arithmetic shift modes, plus a synchronous clear op.
- Adds a burst engine that repeats one op for a programmed count, with busy/done status, so a serialiser or barrel-less multiply/divide datapath can request N-bit shifts without per-cycle control.

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_step_logic.sv | 64 ++++++
 rtl/univ_shift_reg_burst.sv | 129 ++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register with burst engine:
// operation encodings and FSM state type.
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_t;

    // Non-shifting ops perform exactly one step regardless of requested count.
    function automatic logic is_single_shot(input logic [2:0] op);
        return (op == OP_HOLD) || (op == OP_LOAD) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// One-step next-value and next-serial-out computation, shared by the
// single-step and burst paths of the universal shift register.
module usr_step_logic
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] parin,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_sout,
    output logic             sout_upd
);

    // Next register value and shifted-out bit for the selected op.
    always_comb begin
        nxt      = cur;
        nxt_sout = 1'b0;
        sout_upd = 1'b0;
        case (op)
            OP_HOLD: begin
                nxt = cur;
            end
            OP_SHR: begin
                nxt      = {sin_l, cur[WIDTH-1:1]};
                nxt_sout = cur[0];
                sout_upd = 1'b1;
            end
            OP_SHL: begin
                nxt      = {cur[WIDTH-2:0], sin_r};
                nxt_sout = cur[WIDTH-1];
                sout_upd = 1'b1;
            end
            OP_LOAD: begin
                nxt = parin;
            end
            OP_ROR: begin
                nxt      = {cur[0], cur[WIDTH-1:1]};
                nxt_sout = cur[0];
                sout_upd = 1'b1;
            end
            OP_ROL: begin
                nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
                nxt_sout = cur[WIDTH-1];
                sout_upd = 1'b1;
            end
            OP_ASR: begin
                nxt      = {cur[WIDTH-1], cur[WIDTH-1:1]};
                nxt_sout = cur[0];
                sout_upd = 1'b1;
            end
            OP_CLR: begin
                nxt = {WIDTH{1'b0}};
            end
            default: begin
                nxt = cur;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_burst.sv
// Parametrised universal shift register with serial I/O and a burst engine
// that repeats one op for a programmed number of steps.
module univ_shift_reg_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] parin,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    usr_state_t       r_state;
    logic [2:0]       r_op_q;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_nxt;
    logic             w_nxt_sout;
    logic             w_sout_upd;
    logic [CNT_W-1:0] w_start_cnt;

    // In a burst the latched op drives the datapath; otherwise the live op.
    always_comb begin
        if (r_state == ST_RUN) begin
            w_step_op = r_op_q;
        end else begin
            w_step_op = op;
        end
        if (is_single_shot(op)) begin
            w_start_cnt = CNT_ONE;
        end else begin
            w_start_cnt = amt;
        end
    end

    usr_step_logic #(.WIDTH(WIDTH)) u_step (
        .op       (w_step_op),
        .cur      (r_out),
        .parin    (parin),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .nxt      (w_nxt),
        .nxt_sout (w_nxt_sout),
        .sout_upd (w_sout_upd)
    );

    // Burst FSM, step counter, data and status registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_op_q  <= OP_HOLD;
            r_count <= CNT_ZERO;
            r_out   <= {WIDTH{1'b0}};
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_q  <= op;
                        r_count <= w_start_cnt;
                        if (w_start_cnt == CNT_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else if (en) begin
                        r_out <= w_nxt;
                        if (w_sout_upd) begin
                            r_sout <= w_nxt_sout;
                        end else begin
                            r_sout <= r_sout;
                        end
                    end else begin
                        r_out <= r_out;
                    end
                end
                ST_RUN: begin
                    r_out   <= w_nxt;
                    r_count <= r_count - CNT_ONE;
                    if (w_sout_upd) begin
                        r_sout <= w_nxt_sout;
                    end else begin
                        r_sout <= r_sout;
                    end
                    if (r_count == CNT_ONE) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Directed self-checking bench for univ_shift_reg_burst (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg_burst;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       en;
    logic       start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] parin;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] out;
    logic       sout;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (en),
        .start (start),
        .op    (op),
        .amt   (amt),
        .parin (parin),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [7:0] e_out, input logic e_sout,
                                input logic e_busy, input logic e_done);
        check({tag, ".out"}, {24'd0, out}, {24'd0, e_out});
        check({tag, ".sout"}, {31'd0, sout}, {31'd0, e_sout});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    initial begin
        clr_n = 1'b0; en = 1'b0; start = 1'b0; op = 3'd0; amt = 4'd0;
        parin = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        #12;
        check_status("por", 8'h00, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();

        // Async reset with out=A5, no clock edge in between
        op = 3'd3; parin = 8'hA5; en = 1'b1;
        tick();
        en = 1'b0;
        check("load_a5", {24'd0, out}, 32'h0000_00A5);
        #2; clr_n = 1'b0; #1;
        check_status("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();

        // Single steps: LOAD 96, SHR sin_l=1, SHL sin_r=0
        op = 3'd3; parin = 8'h96; en = 1'b1;
        tick();
        check_status("load96", 8'h96, 1'b0, 1'b0, 1'b0);
        op = 3'd1; sin_l = 1'b1;
        tick();
        check_status("shr1", 8'hCB, 1'b0, 1'b0, 1'b0);
        op = 3'd2; sin_r = 1'b0;
        tick();
        check_status("shl1", 8'h96, 1'b1, 1'b0, 1'b0);

        // ROR burst of 3 from 81 with en toggled mid-burst
        op = 3'd3; parin = 8'h81;
        tick();
        en = 1'b0; op = 3'd4; amt = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("ror_k", 8'h81, 1'b1, 1'b1, 1'b0);
        en = 1'b1; op = 3'd3; parin = 8'h00;
        tick();
        check_status("ror_s1", 8'hC0, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        check_status("ror_s2", 8'h60, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        tick();
        check_status("ror_s3", 8'h30, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        tick();
        check_status("ror_after", 8'h30, 1'b0, 1'b0, 1'b0);

        // ASR burst of 7 from 80, then ROL 8 issued in the done cycle
        op = 3'd3; parin = 8'h80; en = 1'b1;
        tick();
        en = 1'b0; op = 3'd6; amt = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("asr_mid.done", {31'd0, done}, 32'd0);
        end
        tick();
        check_status("asr_end", 8'hFF, 1'b0, 1'b0, 1'b1);
        op = 3'd5; amt = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("rol_k", 8'hFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rol_mid.busy", {31'd0, busy}, 32'd1);
        end
        tick();
        check_status("rol_end", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        check_status("rol_after", 8'hFF, 1'b1, 1'b0, 1'b0);

        // amt=0 burst, then LOAD with amt=5 does exactly one step
        op = 3'd1; amt = 4'd0; sin_l = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("amt0", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        check_status("amt0_after", 8'hFF, 1'b1, 1'b0, 1'b0);
        op = 3'd3; amt = 4'd5; parin = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("ldb_k", 8'hFF, 1'b1, 1'b1, 1'b0);
        tick();
        check_status("ldb_s1", 8'h3C, 1'b1, 1'b0, 1'b1);
        tick();
        check_status("ldb_after", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Back-to-back: SHL 2 (sin_r=1) then SHR 1 started in the done cycle
        op = 3'd2; amt = 4'd2; sin_r = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("b2b_k", 8'h3C, 1'b1, 1'b1, 1'b0);
        tick();
        check_status("b2b_s1", 8'h79, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("b2b_s2", 8'hF3, 1'b0, 1'b0, 1'b1);
        op = 3'd1; amt = 4'd1; sin_l = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_status("b2b2_k", 8'hF3, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("b2b2_s1", 8'h79, 1'b1, 1'b0, 1'b1);
        tick();
        check_status("b2b2_after", 8'h79, 1'b1, 1'b0, 1'b0);

        // ROR burst of 6 aborted by reset after step 2
        op = 3'd4; amt = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_status("abort_s1", 8'hBC, 1'b1, 1'b1, 1'b0);
        tick();
        check_status("abort_s2", 8'h5E, 1'b0, 1'b1, 1'b0);
        #2; clr_n = 1'b0; #1;
        check_status("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_nodone", {30'd0, busy, done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
